// File: rtl/writeback_buffer_pkg.sv
// Shared configuration for the writeback path: machine geometry and the
// writeback entry layout reused by the register-file write port.
package writeback_buffer_pkg;

   localparam int NUM_LANES     = 4;
   localparam int MACHINE_WIDTH = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int WARP_ID_W     = 2;

   typedef struct packed {
      logic [NUM_LANES*MACHINE_WIDTH-1:0] data;
      logic [NUM_LANES-1:0]               mask;
      logic [REG_ADDR_W-1:0]              rd;
      logic [WARP_ID_W-1:0]               wid;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_buffer_checker.sv
// Protocol checker for the writeback buffer input: a stalled producer must hold
// its payload steady until the buffer accepts it.
module writeback_buffer_checker #(
   parameter int DW = 8
) (
   input logic          clk,
   input logic          reset,
   input logic          in_valid,
   input logic          in_ready,
   input logic [DW-1:0] in_payload
);

   property p_stall_stable;
      @(posedge clk) disable iff (reset)
         (in_valid && !in_ready) |=> $stable(in_payload);
   endproperty

   a_stall_stable: assert property (p_stall_stable)
      else $error("input payload changed while stalled");

endmodule

// File: rtl/writeback_buffer_wb_fifo.sv
// Generic flop-based FIFO: DEPTH x W storage, wrapping pointers, occupancy
// count and synchronous flush. Callers gate push/pop against full/empty.
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   // Storage, pointers and occupancy; flush discards contents without clearing data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer between the execute stage and the register-file write port:
// filters zero-mask results, gates the handshakes and packs entries into wb_fifo.
module writeback_buffer
   import writeback_buffer_pkg::*;
#(
   parameter int LANES = NUM_LANES,
   parameter int WIDTH = MACHINE_WIDTH,
   parameter int DEPTH = 4,
   parameter int RD_W  = REG_ADDR_W,
   parameter int WID_W = WARP_ID_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_data,
   input  logic [LANES-1:0]         in_mask,
   input  logic [RD_W-1:0]          in_rd,
   input  logic [WID_W-1:0]         in_wid,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   out_data,
   output logic [LANES-1:0]         out_mask,
   output logic [RD_W-1:0]          out_rd,
   output logic [WID_W-1:0]         out_wid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [LANES*WIDTH-1:0] data;
      logic [LANES-1:0]       mask;
      logic [RD_W-1:0]        rd;
      logic [WID_W-1:0]       wid;
   } entry_t;

   entry_t wr_entry_s;
   entry_t rd_entry_s;
   logic   push_s;
   logic   pop_s;

   // Handshake readiness depends only on registered occupancy, never on out_ready.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != {CW{1'b0}});

   // A zero-mask result completes its handshake but writes nothing, so it is dropped here.
   assign push_s = in_valid & in_ready & (|in_mask) & ~flush;
   assign pop_s  = out_valid & out_ready & ~flush;

   assign wr_entry_s = {in_data, in_mask, in_rd, in_wid};

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wr_entry_s),
      .rdata (rd_entry_s),
      .count (count)
   );

   assign out_data = rd_entry_s.data;
   assign out_mask = rd_entry_s.mask;
   assign out_rd   = rd_entry_s.rd;
   assign out_wid  = rd_entry_s.wid;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer (LANES=4, WIDTH=32, DEPTH=4).
module tb_writeback_buffer;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   in_mask;
   logic [4:0]   in_rd;
   logic [1:0]   in_wid;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_mask;
   logic [4:0]   out_rd;
   logic [1:0]   out_wid;
   logic [2:0]   count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   writeback_buffer #(
      .LANES (4), .WIDTH (32), .DEPTH (4), .RD_W (5), .WID_W (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_rd     (in_rd),
      .in_wid    (in_wid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_rd    (out_rd),
      .out_wid   (out_wid),
      .count     (count)
   );

   writeback_buffer_checker #(.DW (139)) u_chk (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_payload ({in_data, in_mask, in_rd, in_wid})
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; outputs are read mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [3:0] mask);
      in_valid = v;
      in_rd    = rd;
      in_mask  = mask;
      in_wid   = rd[1:0];
      in_data  = {4{27'd0, rd}};
   endtask

   int n_out;
   logic [4:0] exp_rd;

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 5'd0, 4'h0);
      in_data = 128'd0;
      step(); step();
      check_eq("rst_count", 128'(count), 128'd0);
      check_eq("rst_out_valid", 128'(out_valid), 128'd0);
      check_eq("rst_in_ready", 128'(in_ready), 128'd1);
      check_eq("rst_out_fields", {out_data[122:0], out_mask, out_rd, out_wid}, 128'd0);
      reset = 1'b0;
      step();

      // 1: single pass
      out_ready = 1'b1;
      in_valid = 1'b1; in_mask = 4'b1011; in_rd = 5'd7; in_wid = 2'd1;
      in_data = {32'd4, 32'd3, 32'd2, 32'd1};
      check_eq("t1_in_ready", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
      check_eq("t1_out_valid", 128'(out_valid), 128'd1);
      check_eq("t1_out_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
      check_eq("t1_out_mask", 128'(out_mask), 128'hB);
      check_eq("t1_out_rd", 128'(out_rd), 128'd7);
      check_eq("t1_out_wid", 128'(out_wid), 128'd1);
      step();
      check_eq("t1_drained_valid", 128'(out_valid), 128'd0);
      check_eq("t1_drained_count", 128'(count), 128'd0);

      // 2: fill with five entries while blocked, then drain in order
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 4'hF);
         step();
      end
      drive(1'b1, 5'd5, 4'hF);
      check_eq("t2_full_in_ready", 128'(in_ready), 128'd0);
      check_eq("t2_full_count", 128'(count), 128'd4);
      step();
      check_eq("t2_held_in_ready", 128'(in_ready), 128'd0);
      check_eq("t2_held_count", 128'(count), 128'd4);
      check_eq("t2_head_stable", 128'(out_rd), 128'd1);
      out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c < 8; c++) begin
         logic accepted;
         accepted = in_valid & in_ready;
         if (out_valid) begin
            n_out++;
            check_eq("t2_drain_rd", 128'(out_rd), 128'(n_out));
         end
         step();
         if (accepted) in_valid = 1'b0;
      end
      check_eq("t2_total_out", 128'(n_out), 128'd5);
      check_eq("t2_final_count", 128'(count), 128'd0);

      // 3: sustained push+pop across pointer wrap
      exp_rd = 5'd0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 5'(i), 4'hF);
         step();
         check_eq("t3_count", 128'(count), 128'd1);
         check_eq("t3_out_rd", 128'(out_rd), 128'(exp_rd));
         exp_rd = exp_rd + 5'd1;
      end
      in_valid = 1'b0;
      step();
      check_eq("t3_empty", 128'(out_valid), 128'd0);
      check_eq("t3_seq_end", 128'(exp_rd), 128'd20);

      // 4: zero-mask input is accepted but not stored
      out_ready = 1'b0;
      drive(1'b1, 5'd10, 4'hF);
      step();
      check_eq("t4_count_a", 128'(count), 128'd1);
      drive(1'b1, 5'd11, 4'h0);
      check_eq("t4_zero_in_ready", 128'(in_ready), 128'd1);
      step();
      check_eq("t4_count_b", 128'(count), 128'd1);
      drive(1'b1, 5'd12, 4'hF);
      step();
      in_valid = 1'b0;
      check_eq("t4_count_c", 128'(count), 128'd2);
      out_ready = 1'b1;
      check_eq("t4_first_rd", 128'(out_rd), 128'd10);
      step();
      check_eq("t4_second_rd", 128'(out_rd), 128'd12);
      step();
      check_eq("t4_empty", 128'(out_valid), 128'd0);

      // 5: flush beats a concurrent push and pop
      out_ready = 1'b0;
      for (int i = 20; i <= 22; i++) begin
         drive(1'b1, 5'(i), 4'hF);
         step();
      end
      check_eq("t5_pre_count", 128'(count), 128'd3);
      drive(1'b1, 5'd23, 4'hF);
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_eq("t5_count", 128'(count), 128'd0);
      check_eq("t5_out_valid", 128'(out_valid), 128'd0);
      step();
      check_eq("t5_still_empty", 128'(out_valid), 128'd0);

      // 6: asynchronous reset mid-cycle while holding two entries
      out_ready = 1'b0;
      drive(1'b1, 5'd30, 4'hF);
      step();
      drive(1'b1, 5'd31, 4'hF);
      step();
      in_valid = 1'b0;
      check_eq("t6_pre_count", 128'(count), 128'd2);
      #2 reset = 1'b1;
      #1;
      check_eq("t6_async_valid", 128'(out_valid), 128'd0);
      check_eq("t6_async_count", 128'(count), 128'd0);
      step();
      reset = 1'b0;
      check_eq("t6_in_ready", 128'(in_ready), 128'd1);
      out_ready = 1'b1;
      in_valid = 1'b1; in_mask = 4'b0101; in_rd = 5'd9; in_wid = 2'd3;
      in_data = {32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 32'h89ABCDEF};
      step();
      in_valid = 1'b0;
      check_eq("t6_out_valid", 128'(out_valid), 128'd1);
      check_eq("t6_out_data", out_data, {32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 32'h89ABCDEF});
      check_eq("t6_out_meta", {out_mask, out_rd, out_wid}, {4'b0101, 5'd9, 2'd3});
      step();
      check_eq("t6_final_count", 128'(count), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
